// File: rtl/quad_encoder_bank_if.sv
// Pin/step/position bundle for quad_encoder_bank; the master side drives the pins and controls,
// and the slave side (the encoder bank) returns step pulses, positions and error status.
interface quad_encoder_bank_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 8
);
  logic [N_CH-1:0]       a;
  logic [N_CH-1:0]       b;
  logic [N_CH-1:0]       invert;
  logic [1:0]            mode;
  logic [N_CH-1:0]       clr;
  logic [N_CH-1:0]       up;
  logic [N_CH-1:0]       down;
  logic [N_CH*CNT_W-1:0] pos;
  logic [N_CH-1:0]       err;
  logic [N_CH*4-1:0]     err_cnt;

  modport master (
    output a, b, invert, mode, clr,
    input  up, down, pos, err, err_cnt
  );

  modport slave (
    input  a, b, invert, mode, clr,
    output up, down, pos, err, err_cnt
  );
endinterface

// File: rtl/quad_encoder_bank.sv
// Multi-channel quadrature decoder: 2-flop sync, per-pin debounce, 1x/2x/4x decode, wrapping position.
// Define ENC_ERR_EN to build the illegal-transition pulse and saturating error counter.
module quad_encoder_bank #(
  parameter int N_CH    = 2,
  parameter int CNT_W   = 8,
  parameter int DEB_CYC = 2
) (
  input logic               clk,
  input logic               reset,
  quad_encoder_bank_if.slave bus
);
  localparam int DW = (DEB_CYC < 1) ? 1 : $clog2(DEB_CYC + 1);

  // Two INIT states give the synchroniser time to hold a real pin sample before it is adopted.
  typedef enum logic [1:0] {ST_INIT0, ST_INIT1, ST_RUN} state_t;
  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= ST_INIT0;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case can infer a latch.
    state_nxt = state;
    case (state)
      ST_INIT0: state_nxt = ST_INIT1;
      default:  state_nxt = ST_RUN;
    endcase
  end

  logic load, run;
  assign load = (state == ST_INIT1);
  assign run  = (state == ST_RUN);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]       s1, s2, deb, prev;
    logic [DW-1:0]    cnt [2];
    logic [CNT_W-1:0] pos_q;
    logic             up_q, dn_q, fwd, rev, keep, step_up, step_dn;

    always_comb begin
      fwd = 1'b0;
      rev = 1'b0;
      case ({prev, deb})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
        4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: rev = 1'b1;
        default: ;
      endcase
      case (bus.mode)
        2'd0:    keep = ~prev[1] & deb[1];
        2'd1:    keep = prev[1] ^ deb[1];
        default: keep = 1'b1;
      endcase
      step_up = run & keep & (bus.invert[i] ? rev : fwd);
      step_dn = run & keep & (bus.invert[i] ? fwd : rev);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        s1    <= '0;
        s2    <= '0;
        deb   <= '0;
        prev  <= '0;
        up_q  <= 1'b0;
        dn_q  <= 1'b0;
        pos_q <= '0;
        for (int p = 0; p < 2; p++) cnt[p] <= '0;
      end else begin
        s1   <= {bus.a[i], bus.b[i]};
        s2   <= s1;
        up_q <= step_up;
        dn_q <= step_dn;
        if (load) begin
          // s1 is the value s2 takes on this edge, so the adopted state is the settled pin level.
          deb  <= s1;
          prev <= s1;
        end else begin
          prev <= deb;
          for (int p = 0; p < 2; p++) begin
            if (!run || s2[p] == deb[p]) begin
              cnt[p] <= '0;
            end else if (cnt[p] == DW'(DEB_CYC)) begin
              deb[p] <= s2[p];
              cnt[p] <= '0;
            end else begin
              cnt[p] <= cnt[p] + DW'(1);
            end
          end
        end
        if (bus.clr[i])   pos_q <= '0;
        else if (step_up) pos_q <= pos_q + CNT_W'(1);
        else if (step_dn) pos_q <= pos_q - CNT_W'(1);
      end
    end

    assign bus.up[i]                 = up_q;
    assign bus.down[i]               = dn_q;
    assign bus.pos[i*CNT_W +: CNT_W] = pos_q;

`ifdef ENC_ERR_EN
    logic       err_q;
    logic [3:0] ecnt_q;
    logic       illegal;
    assign illegal = run & ((prev ^ deb) == 2'b11);

    always_ff @(posedge clk) begin
      if (reset) begin
        err_q  <= 1'b0;
        ecnt_q <= '0;
      end else begin
        err_q <= illegal;
        if (bus.clr[i])                     ecnt_q <= '0;
        else if (illegal && ecnt_q != 4'hF) ecnt_q <= ecnt_q + 4'd1;
      end
    end

    assign bus.err[i]             = err_q;
    assign bus.err_cnt[i*4 +: 4] = ecnt_q;
`else
    assign bus.err[i]             = 1'b0;
    assign bus.err_cnt[i*4 +: 4] = 4'h0;
`endif
  end
endmodule

// File: tb/tb_quad_encoder_bank.sv
// Directed bench for quad_encoder_bank (2 channels, 8-bit position, DEB_CYC=2).
// Follows ENC_ERR_EN so the same sequence covers both builds.
module tb_quad_encoder_bank;
  localparam int N_CH = 2, CNT_W = 8, DEB_CYC = 2;
`ifdef ENC_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  quad_encoder_bank_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();
  quad_encoder_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .DEB_CYC(DEB_CYC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errors = 0, checks = 0;
  int upc[2], dnc[2], errc[2], both_cnt;
  int up_b[2], dn_b[2], err_b[2];
  logic [1:0] p0, p1;
  int lat;

  initial begin
    for (int i = 0; i < 2; i++) begin upc[i] = 0; dnc[i] = 0; errc[i] = 0; end
    both_cnt = 0;
  end

  // Pulse monitor samples 2 time units after each active edge.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      upc[i]  += int'(bus.up[i]);
      dnc[i]  += int'(bus.down[i]);
      errc[i] += int'(bus.err[i]);
    end
    if (|(bus.up & bus.down)) both_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) begin up_b[i] = upc[i]; dn_b[i] = dnc[i]; err_b[i] = errc[i]; end
  endtask

  function automatic logic [1:0] nxt(input logic [1:0] s, input int d);
    if (d > 0) return {~s[0], s[1]};
    if (d < 0) return {s[0], ~s[1]};
    return s;
  endfunction

  task automatic drive();
    bus.a = {p1[1], p0[1]};
    bus.b = {p1[0], p0[0]};
  endtask

  task automatic move(input int d0, input int d1, input int hold);
    @(negedge clk);
    p0 = nxt(p0, d0);
    p1 = nxt(p1, d1);
    drive();
    repeat (hold) @(negedge clk);
  endtask

  task automatic cycle4(input int d0, input int d1);
    for (int k = 0; k < 4; k++) move(d0, d1, 20);
  endtask

  task automatic clr_pulse(input logic [1:0] m);
    @(negedge clk); bus.clr = m;
    @(negedge clk); bus.clr = 2'b00;
  endtask

  function automatic logic [7:0] pos_of(input int ch);
    return (ch == 0) ? bus.pos[7:0] : bus.pos[15:8];
  endfunction

  initial begin
    reset = 1'b1;
    p0 = 2'b00; p1 = 2'b00;
    drive();
    bus.invert = 2'b00; bus.mode = 2'd2; bus.clr = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_up", 32'(bus.up), 0);
    check("rst_down", 32'(bus.down), 0);
    check("rst_pos", 32'(bus.pos), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_err_cnt", 32'(bus.err_cnt), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // 4x: ch0 forward cycle, ch1 reverse cycle at the same time
    snap();
    cycle4(1, -1);
    check("4x_up0", upc[0] - up_b[0], 4);
    check("4x_dn0", dnc[0] - dn_b[0], 0);
    check("4x_pos0", 32'(pos_of(0)), 32'h04);
    check("4x_dn1", dnc[1] - dn_b[1], 4);
    check("4x_pos1", 32'(pos_of(1)), 32'hFC);

    // 2x both forward
    bus.mode = 2'd1; clr_pulse(2'b11);
    check("clr_pos", 32'(bus.pos), 0);
    snap();
    cycle4(1, 1);
    check("2x_up0", upc[0] - up_b[0], 2);
    check("2x_pos0", 32'(pos_of(0)), 32'h02);
    check("2x_pos1", 32'(pos_of(1)), 32'h02);

    // 1x: ch0 forward, ch1 reverse
    bus.mode = 2'd0; clr_pulse(2'b11);
    snap();
    cycle4(1, -1);
    check("1x_up0", upc[0] - up_b[0], 1);
    check("1x_pos0", 32'(pos_of(0)), 32'h01);
    check("1x_dn1", dnc[1] - dn_b[1], 1);
    check("1x_pos1", 32'(pos_of(1)), 32'hFF);

    // Debounce: 2-cycle glitch dropped in 4x, 3-cycle pulse accepted in 1x
    bus.mode = 2'd2; clr_pulse(2'b11);
    snap();
    @(negedge clk); bus.a[0] = 1'b1;
    repeat (2) @(negedge clk); bus.a[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_up0", upc[0] - up_b[0], 0);
    check("glitch_dn0", dnc[0] - dn_b[0], 0);
    check("glitch_pos0", 32'(pos_of(0)), 0);
    bus.mode = 2'd0;
    snap();
    @(negedge clk); bus.a[0] = 1'b1;
    repeat (3) @(negedge clk); bus.a[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("pulse3_up0", upc[0] - up_b[0], 1);
    check("pulse3_dn0", dnc[0] - dn_b[0], 0);
    check("pulse3_pos0", 32'(pos_of(0)), 32'h01);

    // Pin-to-up latency in 4x: edge 0 is the first edge after the change
    bus.mode = 2'd2; clr_pulse(2'b11);
    move(1, 0, 0);
    lat = -1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.up[0] && lat < 0) lat = k;
    end
    check("latency", 32'(lat), 32'(3 + DEB_CYC));
    repeat (10) @(negedge clk);
    check("lat_pos0", 32'(pos_of(0)), 32'h01);

    // Reset with pins at 11: no step out of INIT
    @(negedge clk); reset = 1'b1;
    p0 = 2'b11; p1 = 2'b11; drive();
    repeat (3) @(negedge clk);
    snap();
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("init_up", (upc[0] - up_b[0]) + (upc[1] - up_b[1]), 0);
    check("init_dn", (dnc[0] - dn_b[0]) + (dnc[1] - dn_b[1]), 0);
    check("init_err", (errc[0] - err_b[0]) + (errc[1] - err_b[1]), 0);
    check("init_pos", 32'(bus.pos), 0);
    bus.invert = 2'b10;
    snap();
    move(1, 1, 20);
    check("fwd_up0", upc[0] - up_b[0], 1);
    check("fwd_pos0", 32'(pos_of(0)), 32'h01);
    check("inv_dn1", dnc[1] - dn_b[1], 1);
    check("inv_up1", upc[1] - up_b[1], 0);
    check("inv_pos1", 32'(pos_of(1)), 32'hFF);
    bus.invert = 2'b00;

    // Wrap 0x7F -> 0x80, then clr coinciding with a step
    clr_pulse(2'b11);
    for (int k = 0; k < 127; k++) move(1, 0, 8);
    check("pos_7f", 32'(pos_of(0)), 32'h7F);
    move(1, 0, 8);
    check("pos_80", 32'(pos_of(0)), 32'h80);
    move(1, 0, 0);
    repeat (5) @(negedge clk);
    bus.clr = 2'b01;
    @(negedge clk);
    check("clr_step_up0", 32'(bus.up[0]), 1);
    check("clr_step_pos0", 32'(pos_of(0)), 0);
    bus.clr = 2'b00;
    repeat (10) @(negedge clk);
    check("clr_step_hold", 32'(pos_of(0)), 0);

    // Illegal 00<->11 jumps on ch0; ch1 idle
    clr_pulse(2'b11);
    snap();
    @(negedge clk); p0 = p0 ^ 2'b11; drive();
    repeat (10) @(negedge clk);
    check("ill_err0", errc[0] - err_b[0], 32'(ERR_EN));
    check("ill_cnt0", 32'(bus.err_cnt[3:0]), 32'(ERR_EN));
    check("ill_step", (upc[0] - up_b[0]) + (dnc[0] - dn_b[0]), 0);
    check("ill_pos0", 32'(pos_of(0)), 0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); p0 = p0 ^ 2'b11; drive();
      repeat (8) @(negedge clk);
    end
    check("sat_err0", errc[0] - err_b[0], 32'(17 * ERR_EN));
    check("sat_cnt0", 32'(bus.err_cnt[3:0]), 32'(15 * ERR_EN));
    check("sat_cnt1", 32'(bus.err_cnt[7:4]), 0);
    check("sat_step", (upc[0] - up_b[0]) + (dnc[0] - dn_b[0]), 0);
    check("sat_pos0", 32'(pos_of(0)), 0);
    clr_pulse(2'b01);
    check("clr_err_cnt0", 32'(bus.err_cnt[3:0]), 0);

    check("never_both", 32'(both_cnt), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
